// File: rtl/aes_pkg.sv
// Shared AES definitions: the forward S-box, the GF(2^8) doubling helper and
// the round-constant seed used by the key schedule.
package aes_pkg;

  typedef logic [31:0] word_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: applies the AES S-box to each byte of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t plain,
  output word_t subst
);

  assign subst = {SBOX[plain[31:24]], SBOX[plain[23:16]],
                  SBOX[plain[15:8]],  SBOX[plain[7:0]]};

endmodule

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule producing one expanded word per clock.
// Optional macro KEY_EXPANSION_RK_PORT_EN adds a registered round-key read port.
module key_expansion_seq
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [0:Nk*32-1]          key,
`ifdef KEY_EXPANSION_RK_PORT_EN
  input  logic [3:0]                rk_idx,
  output logic [127:0]              rk_out,
`endif
  output logic                      busy,
  output logic                      done,
  output logic                      words_valid,
  output logic [0:4*(Nr+1)*32-1]    words
);

  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_EXPAND = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  if (!((Nk == 4) || (Nk == 6) || (Nk == 8)) || (Nr != Nk + 6)) begin : g_param_check
    $error("key_expansion_seq: Nk must be 4, 6 or 8 and Nr must equal Nk+6");
  end

  logic [1:0]       state_r;
  logic [IW-1:0]    i_r;
  logic [2:0]       kmod_r;
  logic [7:0]       rcon_r;
  logic             busy_r;
  logic             done_r;
  logic             valid_r;
  logic [0:Nk*32-1] key_r;
  word_t            w_r [NW];

  word_t prev_s;
  word_t back_s;
  word_t rot_s;
  word_t sbox_in_s;
  word_t sbox_out_s;
  word_t temp_s;
  word_t next_word_s;
  logic  is_rot_s;
  logic  is_sub_s;

  // Next-word rule; one S-box word shared by the RotWord and SubWord-only paths.
  always_comb begin
    prev_s    = w_r[i_r - IW'(1)];
    back_s    = w_r[i_r - IW'(Nk)];
    rot_s     = {prev_s[23:0], prev_s[31:24]};
    is_rot_s  = (kmod_r == 3'd0);
    is_sub_s  = (Nk == 8) && (kmod_r == 3'd4);
    sbox_in_s = prev_s;
    if (is_rot_s) begin
      sbox_in_s = rot_s;
    end else begin
      sbox_in_s = prev_s;
    end
    temp_s = prev_s;
    if (is_rot_s) begin
      temp_s = sbox_out_s ^ {rcon_r, 24'h000000};
    end else if (is_sub_s) begin
      temp_s = sbox_out_s;
    end else begin
      temp_s = prev_s;
    end
    next_word_s = back_s ^ temp_s;
  end

  aes_sub_word u_sub_word (
    .plain (sbox_in_s),
    .subst (sbox_out_s)
  );

  // Control FSM: index, mod-Nk counter, round constant and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      i_r     <= '0;
      kmod_r  <= 3'd0;
      rcon_r  <= RCON_INIT;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      key_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
            key_r   <= key;
          end
        end
        ST_LOAD: begin
          i_r     <= IW'(Nk);
          kmod_r  <= 3'd0;
          rcon_r  <= RCON_INIT;
          state_r <= ST_EXPAND;
        end
        ST_EXPAND: begin
          i_r <= i_r + IW'(1);
          if (kmod_r == 3'(Nk - 1)) begin
            kmod_r <= 3'd0;
          end else begin
            kmod_r <= kmod_r + 3'd1;
          end
          if (kmod_r == 3'd0) begin
            rcon_r <= xtime(rcon_r);
          end
          if (i_r == IW'(NW - 1)) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Word storage: key copied in LOAD, one derived word per EXPAND cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) begin
        w_r[k] <= '0;
      end
    end else if (state_r == ST_LOAD) begin
      for (int k = 0; k < Nk; k++) begin
        w_r[k] <= key_r[k*32 +: 32];
      end
    end else if (state_r == ST_EXPAND) begin
      w_r[i_r] <= next_word_s;
    end
  end

  for (genvar k = 0; k < NW; k++) begin : g_words
    assign words[k*32 +: 32] = w_r[k];
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign words_valid = valid_r;

`ifdef KEY_EXPANSION_RK_PORT_EN
  logic [127:0]  rk_out_r;
  logic [IW-1:0] rk_base_s;

  assign rk_base_s = IW'({rk_idx, 2'b00});

  // Round-key read port; an out-of-range round number holds the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_out_r <= '0;
    end else if (rk_idx <= 4'(Nr)) begin
      rk_out_r <= {w_r[rk_base_s], w_r[rk_base_s + IW'(1)],
                   w_r[rk_base_s + IW'(2)], w_r[rk_base_s + IW'(3)]};
    end else begin
      rk_out_r <= rk_out_r;
    end
  end

  assign rk_out = rk_out_r;
`endif

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq using FIPS-197 appendix A key schedules
// for Nk = 4, 6 and 8, plus restart, ignored-start and mid-run reset sequences.
module tb_key_expansion_seq;

  typedef struct {
    int          nk;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start4, start6, start8;
  logic [0:127]     key4;
  logic [0:191]     key6;
  logic [0:255]     key8;
  logic             busy4, busy6, busy8;
  logic             done4, done6, done8;
  logic             valid4, valid6, valid8;
  logic [0:44*32-1] words4;
  logic [0:52*32-1] words6;
  logic [0:60*32-1] words8;
`ifdef KEY_EXPANSION_RK_PORT_EN
  logic [3:0]       rk_idx4, rk_idx6, rk_idx8;
  logic [127:0]     rk_out4, rk_out6, rk_out8;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [16];

  key_expansion_seq #(.Nk(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .key(key4),
`ifdef KEY_EXPANSION_RK_PORT_EN
    .rk_idx(rk_idx4), .rk_out(rk_out4),
`endif
    .busy(busy4), .done(done4), .words_valid(valid4), .words(words4)
  );

  key_expansion_seq #(.Nk(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .key(key6),
`ifdef KEY_EXPANSION_RK_PORT_EN
    .rk_idx(rk_idx6), .rk_out(rk_out6),
`endif
    .busy(busy6), .done(done6), .words_valid(valid6), .words(words6)
  );

  key_expansion_seq #(.Nk(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .key(key8),
`ifdef KEY_EXPANSION_RK_PORT_EN
    .rk_idx(rk_idx8), .rk_out(rk_out8),
`endif
    .busy(busy8), .done(done8), .words_valid(valid8), .words(words8)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_word(input int nk, input int idx);
    case (nk)
      4:       return words4[idx*32 +: 32];
      6:       return words6[idx*32 +: 32];
      default: return words8[idx*32 +: 32];
    endcase
  endfunction

  function automatic logic done_of(input int nk);
    return (nk == 4) ? done4 : (nk == 6) ? done6 : done8;
  endfunction

  function automatic logic busy_of(input int nk);
    return (nk == 4) ? busy4 : (nk == 6) ? busy6 : busy8;
  endfunction

  function automatic logic valid_of(input int nk);
    return (nk == 4) ? valid4 : (nk == 6) ? valid6 : valid8;
  endfunction

  task automatic set_start(input int nk, input logic v);
    case (nk)
      4:       start4 = v;
      6:       start6 = v;
      default: start8 = v;
    endcase
  endtask

  task automatic pulse_start(input int nk);
    @(negedge clk);
    set_start(nk, 1'b1);
    @(posedge clk);
    #1;
    set_start(nk, 1'b0);
  endtask

  // Called #1 after the accepting edge (cycle 1); counts cycles until done.
  task automatic wait_done(input int nk, input int exp_lat, input int inj_cyc);
    int cyc;
    int bad;
    cyc = 1;
    bad = 0;
    while (!done_of(nk) && cyc < 300) begin
      if (valid_of(nk) || !busy_of(nk)) bad++;
      if (inj_cyc != 0 && cyc == inj_cyc) begin
        set_start(nk, 1'b1);
        key4 = '0;
      end else begin
        set_start(nk, 1'b0);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    set_start(nk, 1'b0);
    chk($sformatf("latency_nk%0d", nk), 128'(cyc), 128'(exp_lat));
    chk($sformatf("busy_valid_during_run_nk%0d", nk), 128'(bad), 128'd0);
  endtask

  task automatic post_done(input int nk);
    @(posedge clk);
    #1;
    chk($sformatf("done_pulse_nk%0d", nk), 128'(done_of(nk)), 128'd0);
    chk($sformatf("idle_busy_nk%0d", nk), 128'(busy_of(nk)), 128'd0);
    chk($sformatf("valid_after_nk%0d", nk), 128'(valid_of(nk)), 128'd1);
  endtask

  initial begin
    int ndone;
    vecs[0]  = '{4, 0,  32'h2b7e1516};
    vecs[1]  = '{4, 3,  32'h09cf4f3c};
    vecs[2]  = '{4, 4,  32'ha0fafe17};
    vecs[3]  = '{4, 5,  32'h88542cb1};
    vecs[4]  = '{4, 8,  32'hf2c295f2};
    vecs[5]  = '{4, 40, 32'hd014f9a8};
    vecs[6]  = '{4, 43, 32'hb6630ca6};
    vecs[7]  = '{6, 0,  32'h8e73b0f7};
    vecs[8]  = '{6, 6,  32'hfe0c91f7};
    vecs[9]  = '{6, 7,  32'h2402f5a5};
    vecs[10] = '{6, 51, 32'h01002202};
    vecs[11] = '{8, 0,  32'h603deb10};
    vecs[12] = '{8, 8,  32'h9ba35411};
    vecs[13] = '{8, 9,  32'h8e6925af};
    vecs[14] = '{8, 12, 32'ha8b09c1a};
    vecs[15] = '{8, 59, 32'h706c631e};

    rst_n  = 1'b0;
    start4 = 1'b0;
    start6 = 1'b0;
    start8 = 1'b0;
    key4   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key6   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    key8   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
`ifdef KEY_EXPANSION_RK_PORT_EN
    rk_idx4 = 4'd0;
    rk_idx6 = 4'd0;
    rk_idx8 = 4'd0;
`endif
    #1;
    chk("rst_busy", 128'(busy4), 128'd0);
    chk("rst_done", 128'(done4), 128'd0);
    chk("rst_valid", 128'(valid4), 128'd0);
    chk("rst_words4", 128'(|words4), 128'd0);
    chk("rst_words8", 128'(|words8), 128'd0);
`ifdef KEY_EXPANSION_RK_PORT_EN
    chk("rst_rk_out", rk_out4, 128'd0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Nk=6, then start held through the DONE cycle: ignored there, taken in IDLE.
    pulse_start(6);
    wait_done(6, 48, 0);
    set_start(6, 1'b1);
    @(posedge clk);
    #1;
    chk("start_in_done_ignored", 128'(busy6), 128'd0);
    @(posedge clk);
    #1;
    chk("start_in_idle_busy", 128'(busy6), 128'd1);
    chk("start_in_idle_valid", 128'(valid6), 128'd0);
    set_start(6, 1'b0);
    wait_done(6, 48, 0);
    post_done(6);

    pulse_start(8);
    wait_done(8, 54, 0);
    post_done(8);

    // Nk=4 with a second start and a new key while busy, both to be ignored.
    pulse_start(4);
    wait_done(4, 42, 10);
    post_done(4);

    for (int v = 0; v < 16; v++) begin
      chk($sformatf("w_nk%0d[%0d]", vecs[v].nk, vecs[v].idx),
          128'(get_word(vecs[v].nk, vecs[v].idx)), 128'(vecs[v].exp));
    end

    // Re-expansion with the all-zero key left on the input.
    pulse_start(4);
    wait_done(4, 42, 0);
    post_done(4);
    chk("zero_key_w4", 128'(get_word(4, 4)), 128'h62636363);
    chk("zero_key_w5", 128'(get_word(4, 5)), 128'h62636363);
    chk("zero_key_w8", 128'(get_word(4, 8)), 128'h9b9898c9);

    // Reset in cycle 20 of an A.1 expansion.
    key4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    pulse_start(4);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy4), 128'd0);
    chk("midrst_done", 128'(done4), 128'd0);
    chk("midrst_valid", 128'(valid4), 128'd0);
    chk("midrst_words", 128'(|words4), 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done4 || busy4) ndone++;
    end
    chk("midrst_no_done", 128'(ndone), 128'd0);
    pulse_start(4);
    wait_done(4, 42, 0);
    post_done(4);
    chk("after_rst_w4", 128'(get_word(4, 4)), 128'ha0fafe17);
    chk("after_rst_w43", 128'(get_word(4, 43)), 128'hb6630ca6);

`ifdef KEY_EXPANSION_RK_PORT_EN
    @(negedge clk);
    rk_idx4 = 4'd10;
    @(posedge clk);
    #1;
    chk("rk_out_10", rk_out4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(negedge clk);
    rk_idx4 = 4'd12;
    @(posedge clk);
    #1;
    chk("rk_out_12_hold", rk_out4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(negedge clk);
    rk_idx4 = 4'd0;
    @(posedge clk);
    #1;
    chk("rk_out_0", rk_out4, 128'h2b7e151628aed2a6abf7158809cf4f3c);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
